llmint_scheduler: RTL and testbench

LLMINT_SCHEDULER -- requirements
Module: llmint_scheduler

---
 rtl/llmint_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_llmint_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/llmint_scheduler.sv
// Control scheduler for the dual-precision linear stage: loads N_TILES weight tiles
// through a two-way fork, then streams input vectors through a fork/join pair.
module llmint_scheduler #(
  parameter int N_TILES         = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 16
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             start,
  input  logic [CNT_W-1:0]                                 cfg_num_vectors,
  output logic                                             busy,
  output logic                                             done,
  input  logic                                             wsrc_valid,
  output logic                                             wsrc_ready,
  output logic [((N_TILES > 1) ? $clog2(N_TILES) : 1)-1:0] wsrc_tile,
  output logic                                             hi_weight_valid,
  input  logic                                             hi_weight_ready,
  output logic                                             lo_weight_valid,
  input  logic                                             lo_weight_ready,
  input  logic                                             src_valid,
  output logic                                             src_ready,
  output logic                                             hi_data_valid,
  input  logic                                             hi_data_ready,
  output logic                                             lo_data_valid,
  input  logic                                             lo_data_ready,
  input  logic                                             hi_out_valid,
  output logic                                             hi_out_ready,
  input  logic                                             lo_out_valid,
  output logic                                             lo_out_ready,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [CNT_W-1:0]                                 vec_count,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]             outstanding
);

  localparam int TILE_W = (N_TILES > 1) ? $clog2(N_TILES) : 1;
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(N_TILES - 1);
  localparam logic [OUT_W-1:0]  MAX_OUT   = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_W = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cfg_q, cfg_d;
  logic [CNT_W-1:0]    vec_q, vec_d;
  logic [TILE_W-1:0]   tile_q, tile_d;
  logic [OUT_W-1:0]    outst_q, outst_d;
  logic                hi_wacc_q, hi_wacc_d, lo_wacc_q, lo_wacc_d;
  logic                hi_dacc_q, hi_dacc_d, lo_dacc_q, lo_dacc_d;

  logic in_load_s, in_stream_s, en_s;
  logic w_fire_s, hi_w_hs_s, lo_w_hs_s;
  logic src_fire_s, hi_d_hs_s, lo_d_hs_s, join_fire_s;

  // Fork/join handshake equations; every valid/ready is gated by the owning state.
  always_comb begin
    in_load_s       = (state_q == S_LOAD_W);
    in_stream_s     = (state_q == S_STREAM);
    en_s            = in_stream_s & (vec_q < cfg_q) & (outst_q < MAX_OUT);

    hi_weight_valid = in_load_s & wsrc_valid & ~hi_wacc_q;
    lo_weight_valid = in_load_s & wsrc_valid & ~lo_wacc_q;
    wsrc_ready      = in_load_s & (hi_weight_ready | hi_wacc_q) & (lo_weight_ready | lo_wacc_q);

    hi_data_valid   = src_valid & en_s & ~hi_dacc_q;
    lo_data_valid   = src_valid & en_s & ~lo_dacc_q;
    src_ready       = en_s & (hi_data_ready | hi_dacc_q) & (lo_data_ready | lo_dacc_q);

    out_valid       = in_stream_s & hi_out_valid & lo_out_valid;
    hi_out_ready    = in_stream_s & out_ready & lo_out_valid;
    lo_out_ready    = in_stream_s & out_ready & hi_out_valid;

    w_fire_s        = wsrc_valid & wsrc_ready;
    hi_w_hs_s       = hi_weight_valid & hi_weight_ready;
    lo_w_hs_s       = lo_weight_valid & lo_weight_ready;
    src_fire_s      = src_valid & src_ready;
    hi_d_hs_s       = hi_data_valid & hi_data_ready;
    lo_d_hs_s       = lo_data_valid & lo_data_ready;
    join_fire_s     = out_valid & out_ready;

    busy            = (state_q != S_IDLE);
    done            = (state_q == S_DONE);
    wsrc_tile       = tile_q;
    vec_count       = vec_q;
    outstanding     = outst_q;
  end

  // Next-state computation for the FSM, counters and per-branch accepted flags.
  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    vec_d     = vec_q;
    tile_d    = tile_q;
    outst_d   = outst_q;
    hi_wacc_d = hi_wacc_q;
    lo_wacc_d = lo_wacc_q;
    hi_dacc_d = hi_dacc_q;
    lo_dacc_d = lo_dacc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_d     = cfg_num_vectors;
          vec_d     = '0;
          tile_d    = '0;
          outst_d   = '0;
          hi_wacc_d = 1'b0;
          lo_wacc_d = 1'b0;
          hi_dacc_d = 1'b0;
          lo_dacc_d = 1'b0;
          state_d   = (cfg_num_vectors != '0) ? S_LOAD_W : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD_W: begin
        if (w_fire_s) begin
          hi_wacc_d = 1'b0;
          lo_wacc_d = 1'b0;
          if (tile_q == LAST_TILE) begin
            tile_d  = '0;
            state_d = S_STREAM;
          end else begin
            tile_d  = tile_q + TILE_W'(1);
          end
        end else begin
          hi_wacc_d = hi_wacc_q | hi_w_hs_s;
          lo_wacc_d = lo_wacc_q | lo_w_hs_s;
        end
      end

      S_STREAM: begin
        if (src_fire_s) begin
          hi_dacc_d = 1'b0;
          lo_dacc_d = 1'b0;
          vec_d     = vec_q + CNT_W'(1);
        end else begin
          hi_dacc_d = hi_dacc_q | hi_d_hs_s;
          lo_dacc_d = lo_dacc_q | lo_d_hs_s;
        end
        // A join with nothing in flight is an upstream protocol error; keep the count sane.
        case ({src_fire_s, join_fire_s})
          2'b10:   outst_d = outst_q + OUT_W'(1);
          2'b01:   outst_d = (outst_q != '0) ? (outst_q - OUT_W'(1)) : outst_q;
          default: outst_d = outst_q;
        endcase
        if ((vec_q == cfg_q) && (outst_q == '0)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_STREAM;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cfg_q     <= '0;
      vec_q     <= '0;
      tile_q    <= '0;
      outst_q   <= '0;
      hi_wacc_q <= 1'b0;
      lo_wacc_q <= 1'b0;
      hi_dacc_q <= 1'b0;
      lo_dacc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      vec_q     <= vec_d;
      tile_q    <= tile_d;
      outst_q   <= outst_d;
      hi_wacc_q <= hi_wacc_d;
      lo_wacc_q <= lo_wacc_d;
      hi_dacc_q <= hi_dacc_d;
      lo_dacc_q <= lo_dacc_d;
    end
  end

endmodule

// File: tb/tb_llmint_scheduler.sv
// Self-checking bench for llmint_scheduler: scoreboarded tile order and issue/join
// tracking against a small behavioural model of the batch flow.
module tb_llmint_scheduler;

  localparam int NT      = 2;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] cfg_num_vectors;
  logic        busy, done;
  logic        wsrc_valid, wsrc_ready;
  logic [0:0]  wsrc_tile;
  logic        hi_weight_valid, hi_weight_ready, lo_weight_valid, lo_weight_ready;
  logic        src_valid, src_ready;
  logic        hi_data_valid, hi_data_ready, lo_data_valid, lo_data_ready;
  logic        hi_out_valid, hi_out_ready, lo_out_valid, lo_out_ready;
  logic        out_valid, out_ready;
  logic [15:0] vec_count;
  logic [1:0]  outstanding;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  llmint_scheduler #(.N_TILES(NT), .MAX_OUTSTANDING(MAX_OUT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_num_vectors(cfg_num_vectors),
    .busy(busy), .done(done),
    .wsrc_valid(wsrc_valid), .wsrc_ready(wsrc_ready), .wsrc_tile(wsrc_tile),
    .hi_weight_valid(hi_weight_valid), .hi_weight_ready(hi_weight_ready),
    .lo_weight_valid(lo_weight_valid), .lo_weight_ready(lo_weight_ready),
    .src_valid(src_valid), .src_ready(src_ready),
    .hi_data_valid(hi_data_valid), .hi_data_ready(hi_data_ready),
    .lo_data_valid(lo_data_valid), .lo_data_ready(lo_data_ready),
    .hi_out_valid(hi_out_valid), .hi_out_ready(hi_out_ready),
    .lo_out_valid(lo_out_valid), .lo_out_ready(lo_out_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .vec_count(vec_count), .outstanding(outstanding)
  );

  // Runs one batch with always-valid sources; downstream results return lat cycles
  // after issue; lo_weight_ready is held low for the first stall cycles of LOAD_W.
  task automatic run_batch(input int cfg, input int lat, input int stall, input bit expect_sim);
    int issued = 0, joined = 0, done_cnt = 0, cyc = 0;
    int last_join = -1, done_cyc = -1, hi_v = 0, lo_v = 0, tiles = 0;
    int hi_hs = 0, lo_hs = 0, wr_low = 0, sim_cnt = 0, et, ob;
    bit stream_m = 0, stream_n = 0, any_valid = 0, sf, jf;
    int pending[$];
    int exp_tile[$];
    if (cfg > 0) for (int t = 0; t < NT; t++) exp_tile.push_back(t);
    start = 1'b1; cfg_num_vectors = 16'(cfg);
    wsrc_valid = 1'b1; src_valid = 1'b1; out_ready = 1'b1;
    hi_weight_ready = 1'b1; hi_data_ready = 1'b1; lo_data_ready = 1'b1;
    lo_weight_ready = (stall > 0) ? 1'b0 : 1'b1;
    hi_out_valid = 1'b0; lo_out_valid = 1'b0;
    @(posedge clk); #1; start = 1'b0; cyc = 1;
    while (done_cnt == 0 && cyc < 500) begin
      lo_weight_ready = (cyc <= stall) ? 1'b0 : 1'b1;
      hi_out_valid = (pending.size() > 0) && (pending[0] + lat <= cyc);
      lo_out_valid = hi_out_valid;
      @(negedge clk);
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1) $display("FAIL busy_after_start: got %b want 1", busy); else passed++;
        if (cfg > 0) begin
          checks++;
          if (hi_weight_valid !== 1'b1) $display("FAIL start_to_wvalid: got %b want 1", hi_weight_valid); else passed++;
        end
      end
      if (hi_weight_valid) hi_v++;
      if (lo_weight_valid) lo_v++;
      if (hi_weight_valid || lo_weight_valid || hi_data_valid || lo_data_valid) any_valid = 1;
      if (hi_weight_valid && hi_weight_ready) hi_hs++;
      if (lo_weight_valid && lo_weight_ready) lo_hs++;
      if (cfg > 0 && tiles < NT && !wsrc_ready) wr_low++;
      ob = issued - joined;
      checks++;
      if (outstanding !== 2'(ob)) $display("FAIL outstanding: got %0d want %0d (cycle %0d)", outstanding, ob, cyc); else passed++;
      checks++;
      if (src_ready !== (stream_m && issued < cfg && ob < MAX_OUT))
        $display("FAIL src_ready: got %b want %b (cycle %0d)", src_ready, (stream_m && issued < cfg && ob < MAX_OUT), cyc);
      else passed++;
      if (wsrc_valid && wsrc_ready) begin
        checks++;
        if (exp_tile.size() == 0) $display("FAIL tile_order: got tile %0d want none", wsrc_tile);
        else begin
          et = exp_tile.pop_front();
          if (int'(wsrc_tile) !== et) $display("FAIL tile_order: got %0d want %0d", wsrc_tile, et); else passed++;
        end
        checks++;
        if (hi_hs != 1 || lo_hs != 1) $display("FAIL fork_once: got hi=%0d lo=%0d want 1/1", hi_hs, lo_hs); else passed++;
        hi_hs = 0; lo_hs = 0; tiles++;
        if (tiles == NT) stream_n = 1;
      end
      sf = src_valid && src_ready;
      jf = out_valid && out_ready;
      if (sf) begin
        checks++;
        if (vec_count !== 16'(issued)) $display("FAIL vec_count: got %0d want %0d", vec_count, issued); else passed++;
        issued++; pending.push_back(cyc);
      end
      if (jf) begin
        checks++;
        if (pending.size() == 0) $display("FAIL join_unexpected: got join want none");
        else begin void'(pending.pop_front()); passed++; end
        joined++; last_join = cyc;
      end
      if (sf && jf && ob == 1) sim_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      stream_m = stream_n;
      @(posedge clk); #1; cyc++;
    end
    hi_out_valid = 1'b0; lo_out_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done_cnt !== 1) $display("FAIL done_seen: got %0d want 1", done_cnt); else passed++;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL after_done: got busy=%b done=%b want 0/0", busy, done); else passed++;
    checks++;
    if (issued != cfg || joined != cfg) $display("FAIL handshakes: got %0d/%0d want %0d", issued, joined, cfg); else passed++;
    checks++;
    if (exp_tile.size() != 0 || tiles != ((cfg > 0) ? NT : 0)) $display("FAIL tiles_loaded: got %0d want %0d", tiles, (cfg > 0) ? NT : 0); else passed++;
    checks++;
    if (hi_v != ((cfg > 0) ? NT : 0) || lo_v != ((cfg > 0) ? NT + stall : 0))
      $display("FAIL wvalid_cycles: got hi=%0d lo=%0d want %0d/%0d", hi_v, lo_v, (cfg > 0) ? NT : 0, (cfg > 0) ? NT + stall : 0);
    else passed++;
    checks++;
    if (wr_low != stall) $display("FAIL wsrc_stall: got %0d want %0d", wr_low, stall); else passed++;
    checks++;
    if (cfg > 0) begin
      if (done_cyc - last_join != 2) $display("FAIL join_to_done: got %0d want 2", done_cyc - last_join); else passed++;
    end else begin
      if (done_cyc != 1 || any_valid) $display("FAIL zero_cfg: got done_cyc=%0d valids=%b want 1/0", done_cyc, any_valid); else passed++;
    end
    if (expect_sim) begin
      checks++;
      if (sim_cnt == 0) $display("FAIL issue_join_same_cycle: got %0d want >0", sim_cnt); else passed++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; cfg_num_vectors = 16'd7;
    wsrc_valid = 1'b1; src_valid = 1'b1; hi_out_valid = 1'b1; lo_out_valid = 1'b1; out_ready = 1'b1;
    hi_weight_ready = 1'b1; lo_weight_ready = 1'b1; hi_data_ready = 1'b1; lo_data_ready = 1'b1;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      #1; @(negedge clk);
      checks++;
      if ({busy, done, wsrc_ready, hi_weight_valid, lo_weight_valid, src_ready, hi_data_valid,
           lo_data_valid, out_valid, hi_out_ready, lo_out_ready} !== 11'd0)
        $display("FAIL reset_outputs: got %b want 0", {busy, done, wsrc_ready, hi_weight_valid, lo_weight_valid,
                 src_ready, hi_data_valid, lo_data_valid, out_valid, hi_out_ready, lo_out_ready});
      else passed++;
      checks++;
      if (vec_count !== 16'd0 || outstanding !== 2'd0) $display("FAIL reset_counters: got %0d/%0d want 0/0", vec_count, outstanding); else passed++;
      rst = 1'b1;
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_basic();            run_batch(3, 1, 0, 1'b1); endtask
  task automatic test_varied();           run_batch(5, 3, 0, 1'b0); run_batch(1, 1, 0, 1'b0); endtask
  task automatic test_weight_stall();     run_batch(2, 1, 3, 1'b0); endtask
  task automatic test_outstanding_limit(); run_batch(4, 6, 0, 1'b0); endtask
  task automatic test_zero_cfg();         run_batch(0, 1, 0, 1'b0); endtask
  task automatic test_back_to_back();     run_batch(2, 2, 0, 1'b0); run_batch(3, 1, 1, 1'b1); endtask

  task automatic test_reset_mid();
    bit hit = 0;
    start = 1'b1; cfg_num_vectors = 16'd4;
    hi_out_valid = 1'b0; lo_out_valid = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 30 && !hit; k++) begin
      @(negedge clk);
      if (outstanding == 2'd2) hit = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (!hit) $display("FAIL mid_reach_outstanding: got %0d want 2", outstanding); else passed++;
    rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || vec_count !== 16'd0 || outstanding !== 2'd0)
      $display("FAIL mid_reset_state: got busy=%b vec=%0d out=%0d want 0/0/0", busy, vec_count, outstanding);
    else passed++;
    checks++;
    if ({wsrc_ready, hi_weight_valid, src_ready, hi_data_valid, lo_data_valid} !== 5'd0)
      $display("FAIL mid_reset_handshakes: got %b want 0", {wsrc_ready, hi_weight_valid, src_ready, hi_data_valid, lo_data_valid});
    else passed++;
    @(posedge clk); #1;
    run_batch(2, 1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_varied();
    test_weight_stall();
    test_outstanding_limit();
    test_zero_cfg();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
